// File: rtl/ahb2apb_bridge_mp.sv
// AHB-Lite slave to multi-slot APB4 bridge. One transfer is in flight at a time. The address
// selects the APB slot. pslverr becomes a two-cycle AHB ERROR, and an over-long ACCESS is aborted.
module ahb2apb_bridge_mp #(
  parameter int ADDR_W      = 32,
  parameter int NUM_PSLV    = 4,
  parameter int SLOT_W      = 12,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                  bclk,
  input  logic                  bresetn,
  input  logic                  s_hsel,
  input  logic [1:0]            s_htrans,
  input  logic [ADDR_W-1:0]     s_haddr,
  input  logic                  s_hwrite,
  input  logic [2:0]            s_hsize,
  input  logic [3:0]            s_hprot,
  input  logic [31:0]           s_hwdata,
  input  logic                  s_hready,
  output logic                  s_hreadyout,
  output logic [31:0]           s_hrdata,
  output logic [1:0]            s_hresp,
  output logic [NUM_PSLV-1:0]   m_psel,
  output logic                  m_penable,
  output logic [ADDR_W-1:0]     m_paddr,
  output logic                  m_pwrite,
  output logic [31:0]           m_pwdata,
  output logic [2:0]            m_pprot,
  output logic [3:0]            m_pstrb,
  input  logic [32*NUM_PSLV-1:0] m_prdata,
  input  logic [NUM_PSLV-1:0]   m_pready,
  input  logic [NUM_PSLV-1:0]   m_pslverr,
  output logic [2:0]            dbg_state
);

  localparam int IDX_W = (NUM_PSLV > 1) ? $clog2(NUM_PSLV) : 1;
  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LATCH  = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERR1   = 3'd5,
    ST_ERR2   = 3'd6
  } state_t;

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   addr_q;
  logic                write_q;
  logic [IDX_W-1:0]    idx_q;
  logic [2:0]          pprot_q;
  logic [3:0]          pstrb_q;
  logic [31:0]         wdata_q;
  logic [31:0]         rdata_q;
  logic [CNT_W-1:0]    cnt;

  logic                phase_ok;
  logic                accept;
  logic [IDX_W-1:0]    hidx;
  logic                hbad;
  logic [3:0]          strb_nx;
  logic [NUM_PSLV-1:0] slot_oh;
  logic                sel_ready;
  logic                sel_err;
  logic [31:0]         sel_rdata;
  logic                timeout_hit;
  logic                unused_bits;

  // Handshakes: an AHB address phase is taken on a rising edge where s_hsel, s_htrans[1] and
  // s_hready are all high and the bridge is free (IDLE, DONE or ERR2). An APB access ends on
  // the first ACCESS edge where the selected slot drives pready high.
  assign phase_ok = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR2);
  assign accept   = phase_ok && s_hsel && s_hready && s_htrans[1];
  assign hidx     = s_haddr[SLOT_W+IDX_W-1:SLOT_W];
  assign hbad     = (32'(hidx) >= 32'(NUM_PSLV)) || (s_hsize > 3'd2);

  always_comb begin
    strb_nx = 4'h0;
    if (s_hwrite) begin
      case (s_hsize)
        3'd0:    strb_nx = 4'b0001 << s_haddr[1:0];
        3'd1:    strb_nx = 4'b0011 << {s_haddr[1], 1'b0};
        3'd2:    strb_nx = 4'hF;
        default: strb_nx = 4'h0;
      endcase
    end
  end

  // Slot muxing goes through a one-hot decode, so any NUM_PSLV works without out-of-range indexing.
  always_comb begin
    slot_oh   = '0;
    sel_rdata = '0;
    for (int k = 0; k < NUM_PSLV; k++) begin
      slot_oh[k] = (32'(idx_q) == k);
      sel_rdata  = sel_rdata | (m_prdata[32*k +: 32] & {32{slot_oh[k]}});
    end
  end

  assign sel_ready = |(m_pready & slot_oh);
  assign sel_err   = |(m_pslverr & slot_oh);

  if (TIMEOUT_CYC > 0) begin : g_timeout
    assign timeout_hit = (cnt == CNT_W'(TIMEOUT_CYC - 1));
  end else begin : g_no_timeout
    assign timeout_hit = 1'b0;
  end

  always_ff @(posedge bclk or negedge bresetn) begin
    if (!bresetn) begin
      state   <= ST_IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      idx_q   <= '0;
      pprot_q <= 3'b000;
      pstrb_q <= 4'h0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt     <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        addr_q  <= s_haddr;
        write_q <= s_hwrite;
        idx_q   <= hidx;
        pprot_q <= {~s_hprot[0], 1'b0, s_hprot[1]};
        pstrb_q <= strb_nx;
      end
      if (state == ST_LATCH && write_q) begin
        wdata_q <= s_hwdata;
      end
      // The counter holds the number of ACCESS cycles already spent without pready.
      if (state == ST_LATCH) begin
        cnt <= '0;
      end else if (state == ST_ACCESS && TIMEOUT_CYC > 0) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (state == ST_ACCESS && sel_ready && !sel_err && !write_q) begin
        rdata_q <= sel_rdata;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR2: begin
        if (accept) state_nx = hbad ? ST_ERR1 : ST_LATCH;
        else        state_nx = ST_IDLE;
      end
      ST_LATCH:  state_nx = ST_SETUP;
      ST_SETUP:  state_nx = ST_ACCESS;
      ST_ACCESS: begin
        if (sel_ready)        state_nx = sel_err ? ST_ERR1 : ST_DONE;
        else if (timeout_hit) state_nx = ST_ERR1;
      end
      ST_ERR1:   state_nx = ST_ERR2;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    s_hreadyout = 1'b1;
    s_hresp     = 2'b00;
    m_psel      = '0;
    m_penable   = 1'b0;
    case (state)
      ST_LATCH:  s_hreadyout = 1'b0;
      ST_SETUP: begin
        s_hreadyout = 1'b0;
        m_psel      = slot_oh;
      end
      ST_ACCESS: begin
        s_hreadyout = 1'b0;
        m_psel      = slot_oh;
        m_penable   = 1'b1;
      end
      ST_ERR1: begin
        s_hreadyout = 1'b0;
        s_hresp     = 2'b01;
      end
      ST_ERR2:   s_hresp = 2'b01;
      default: ;
    endcase
  end

  assign m_paddr   = addr_q;
  assign m_pwrite  = write_q;
  assign m_pwdata  = wdata_q;
  assign m_pprot   = pprot_q;
  assign m_pstrb   = pstrb_q;
  assign s_hrdata  = rdata_q;
  assign dbg_state = state;

  assign unused_bits = ^{s_hprot[3:2], cnt};

endmodule

// File: tb/tb_ahb2apb_bridge_mp.sv
// Bench for ahb2apb_bridge_mp. Five slots with TIMEOUT_CYC=8, so slot indices 5..7 fall outside the map.
module tb_ahb2apb_bridge_mp;

  localparam int ADDR_W      = 32;
  localparam int NUM_PSLV    = 5;
  localparam int SLOT_W      = 12;
  localparam int TIMEOUT_CYC = 8;

  logic                   bclk;
  logic                   bresetn;
  logic                   s_hsel;
  logic [1:0]             s_htrans;
  logic [ADDR_W-1:0]      s_haddr;
  logic                   s_hwrite;
  logic [2:0]             s_hsize;
  logic [3:0]             s_hprot;
  logic [31:0]            s_hwdata;
  logic                   s_hready;
  logic                   s_hreadyout;
  logic [31:0]            s_hrdata;
  logic [1:0]             s_hresp;
  logic [NUM_PSLV-1:0]    m_psel;
  logic                   m_penable;
  logic [ADDR_W-1:0]      m_paddr;
  logic                   m_pwrite;
  logic [31:0]            m_pwdata;
  logic [2:0]             m_pprot;
  logic [3:0]             m_pstrb;
  logic [32*NUM_PSLV-1:0] m_prdata;
  logic [NUM_PSLV-1:0]    m_pready;
  logic [NUM_PSLV-1:0]    m_pslverr;
  logic [2:0]             dbg_state;

  assign s_hready = s_hreadyout;

  ahb2apb_bridge_mp #(
    .ADDR_W(ADDR_W), .NUM_PSLV(NUM_PSLV), .SLOT_W(SLOT_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .bclk(bclk), .bresetn(bresetn),
    .s_hsel(s_hsel), .s_htrans(s_htrans), .s_haddr(s_haddr), .s_hwrite(s_hwrite),
    .s_hsize(s_hsize), .s_hprot(s_hprot), .s_hwdata(s_hwdata), .s_hready(s_hready),
    .s_hreadyout(s_hreadyout), .s_hrdata(s_hrdata), .s_hresp(s_hresp),
    .m_psel(m_psel), .m_penable(m_penable), .m_paddr(m_paddr), .m_pwrite(m_pwrite),
    .m_pwdata(m_pwdata), .m_pprot(m_pprot), .m_pstrb(m_pstrb),
    .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  initial begin
    bclk = 1'b0;
    forever #5 bclk = ~bclk;
  end

  typedef struct packed {
    logic        err;
    logic [7:0]  waits;
    logic [31:0] rdata;
  } ahb_exp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  slot;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    logic [7:0]  n_acc;
    logic        ready;
    logic        err;
  } apb_exp_t;

  localparam int AHB_W = $bits(ahb_exp_t);

  logic [AHB_W-1:0] exp_q[$];
  apb_exp_t         apb_q[$];
  logic [31:0]      ref_mem [NUM_PSLV][16];
  logic [31:0]      slv_mem [NUM_PSLV][16];
  logic [31:0]      last_rdata;
  logic             ahb_mon_en;
  logic             apb_mon_en;
  int               tests;
  int               fails;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_strb(input logic write, input logic [2:0] size,
                                          input logic [31:0] addr);
    if (!write) return 4'h0;
    case (size)
      3'd0:    return 4'(1 << (addr % 4));
      3'd1:    return 4'(3 << (addr & 32'd2));
      default: return 4'hF;
    endcase
  endfunction

  // Driver: builds the expectation from the address map and the slave behaviour, then
  // presents the address phase until accepted and drives write data in the data phase.
  task automatic issue(input logic [31:0] addr, input logic write, input logic [2:0] size,
                       input logic [3:0] prot, input logic [31:0] wdata, input int wait_n,
                       input logic slv_err, input logic hang);
    ahb_exp_t e;
    apb_exp_t a;
    int slot;
    int w;
    int guard;
    logic [3:0] strb;
    slot = int'((addr >> SLOT_W) % 8);
    w    = int'((addr >> 2) % 16);
    strb = exp_strb(write, size, addr);
    e    = '0;
    if (slot >= NUM_PSLV || size > 3'd2) begin
      e.err   = 1'b1;
      e.waits = 8'd1;
    end else begin
      a.addr  = addr;
      a.slot  = 4'(slot);
      a.write = write;
      a.wdata = write ? wdata : 32'h0;
      a.strb  = strb;
      a.prot  = {~prot[0], 1'b0, prot[1]};
      if (hang) begin
        a.n_acc = 8'(TIMEOUT_CYC);
        a.ready = 1'b0;
        a.err   = 1'b0;
        e.err   = 1'b1;
        e.waits = 8'(2 + TIMEOUT_CYC + 1);
      end else begin
        a.n_acc = 8'(wait_n + 1);
        a.ready = 1'b1;
        a.err   = slv_err;
        e.err   = slv_err;
        e.waits = 8'(2 + wait_n + 1 + (slv_err ? 1 : 0));
        if (!slv_err) begin
          if (write) begin
            for (int b = 0; b < 4; b++)
              if (strb[b]) ref_mem[slot][w][8*b +: 8] = wdata[8*b +: 8];
          end else begin
            last_rdata = ref_mem[slot][w];
          end
        end
      end
      apb_q.push_back(a);
    end
    e.rdata = last_rdata;
    exp_q.push_back(e);

    s_hsel   = 1'b1;
    s_htrans = 2'b10;
    s_haddr  = addr;
    s_hwrite = write;
    s_hsize  = size;
    s_hprot  = prot;
    guard = 0;
    while (!s_hreadyout && guard < 100) begin
      @(posedge bclk); #2;
      guard++;
    end
    if (guard >= 100) chk("drv_accept", 64'(s_hreadyout), 64'd1);
    @(posedge bclk); #2;
    s_hsel   = 1'b0;
    s_htrans = 2'b00;
    s_hwdata = write ? wdata : $urandom;
  endtask

  task automatic idle(input int n);
    s_hsel   = 1'b0;
    s_htrans = 2'b00;
    repeat (n) begin
      @(posedge bclk); #2;
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    s_hsel   = 1'b0;
    s_htrans = 2'b00;
    while ((exp_q.size() != 0 || apb_q.size() != 0) && g < 1000) begin
      @(posedge bclk); #2;
      g++;
    end
    chk("drain_ahb_q", 64'(exp_q.size()), 64'd0);
    chk("drain_apb_q", 64'(apb_q.size()), 64'd0);
    idle(2);
  endtask

  // AHB monitor: counts wait states for each data phase and scores the completion.
  initial begin : ahb_mon
    logic pend;
    int waits;
    logic [1:0] prev_resp;
    ahb_exp_t e;
    pend = 1'b0;
    waits = 0;
    prev_resp = 2'b00;
    forever begin
      @(negedge bclk);
      if (!bresetn || !ahb_mon_en) begin
        pend  = 1'b0;
        waits = 0;
      end else if (!s_hreadyout) begin
        if (!pend) begin
          chk("hreadyout_idle", 64'(s_hreadyout), 64'd1);
        end else begin
          waits++;
          prev_resp = s_hresp;
          if (waits > 200) begin
            chk("ahb_stall", 64'(s_hreadyout), 64'd1);
            pend = 1'b0;
          end
        end
      end else begin
        if (pend && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("hresp", 64'(s_hresp), e.err ? 64'd1 : 64'd0);
          chk("hresp_prev", 64'(prev_resp), e.err ? 64'd1 : 64'd0);
          chk("wait_states", 64'(waits), 64'(e.waits));
          chk("hrdata", 64'(s_hrdata), 64'(e.rdata));
        end
        pend  = s_hsel && s_htrans[1];
        waits = 0;
      end
    end
  end

  // APB slave model plus monitor: checks each SETUP against the queue, responds in ACCESS.
  initial begin : apb_side
    apb_exp_t cur;
    int acc;
    int w;
    logic active;
    logic [63:0] hold_a;
    logic [63:0] hold_b;
    active = 1'b0;
    acc = 0;
    cur = '0;
    forever begin
      @(posedge bclk); #2;
      m_pready  = '0;
      m_pslverr = '0;
      for (int k = 0; k < NUM_PSLV; k++) m_prdata[32*k +: 32] = $urandom;
      if (!bresetn || !apb_mon_en) begin
        active = 1'b0;
        acc = 0;
      end else if (m_psel != '0 && !m_penable) begin
        if (apb_q.size() == 0) begin
          chk("apb_unexpected", 64'(m_psel), 64'd0);
        end else begin
          cur = apb_q.pop_front();
          active = 1'b1;
          acc = 0;
          chk("psel", 64'(m_psel), 64'd1 << cur.slot);
          chk("paddr", 64'(m_paddr), 64'(cur.addr));
          chk("pwrite", 64'(m_pwrite), 64'(cur.write));
          chk("pstrb", 64'(m_pstrb), 64'(cur.strb));
          chk("pprot", 64'(m_pprot), 64'(cur.prot));
          if (cur.write) chk("pwdata", 64'(m_pwdata), 64'(cur.wdata));
          hold_a = {m_paddr, m_pwdata};
          hold_b = 64'({m_psel, m_pwrite, m_pstrb, m_pprot});
        end
      end else if (m_psel != '0 && m_penable && active) begin
        acc++;
        chk("apb_hold_a", {m_paddr, m_pwdata}, hold_a);
        chk("apb_hold_b", 64'({m_psel, m_pwrite, m_pstrb, m_pprot}), hold_b);
        if (acc > int'(cur.n_acc)) begin
          chk("apb_access_len", 64'(acc), 64'(cur.n_acc));
          active = 1'b0;
        end else if (cur.ready && acc == int'(cur.n_acc)) begin
          w = int'((m_paddr >> 2) % 16);
          m_pready[cur.slot]  = 1'b1;
          m_pslverr[cur.slot] = cur.err;
          if (cur.write) begin
            m_prdata[32*cur.slot +: 32] = $urandom;
            if (!cur.err)
              for (int b = 0; b < 4; b++)
                if (m_pstrb[b]) slv_mem[cur.slot][w][8*b +: 8] = m_pwdata[8*b +: 8];
          end else begin
            m_prdata[32*cur.slot +: 32] = slv_mem[cur.slot][w];
          end
        end
      end else if (active) begin
        chk("apb_access_len", 64'(acc), 64'(cur.n_acc));
        chk("penable_drop", 64'(m_penable), 64'd0);
        active = 1'b0;
      end
    end
  end

  initial begin : main
    int guard;
    int slot;
    int off;
    logic [2:0] size;
    logic [31:0] v;
    tests = 0;
    fails = 0;
    last_rdata = 32'h0;
    ahb_mon_en = 1'b1;
    apb_mon_en = 1'b1;
    bresetn  = 1'b0;
    s_hsel   = 1'b0;
    s_htrans = 2'b00;
    s_haddr  = '0;
    s_hwrite = 1'b0;
    s_hsize  = 3'd0;
    s_hprot  = 4'h0;
    s_hwdata = '0;
    m_prdata = '0;
    m_pready = '0;
    m_pslverr = '0;
    for (int k = 0; k < NUM_PSLV; k++)
      for (int i = 0; i < 16; i++) begin
        v = $urandom;
        ref_mem[k][i] = v;
        slv_mem[k][i] = v;
      end
    ref_mem[1][0] = 32'h1122_3344;
    slv_mem[1][0] = 32'h1122_3344;

    #1;
    chk("rst_hreadyout", 64'(s_hreadyout), 64'd1);
    chk("rst_hresp", 64'(s_hresp), 64'd0);
    chk("rst_hrdata", 64'(s_hrdata), 64'd0);
    chk("rst_psel", 64'(m_psel), 64'd0);
    chk("rst_penable", 64'(m_penable), 64'd0);
    chk("rst_paddr", 64'(m_paddr), 64'd0);
    chk("rst_pwrite", 64'(m_pwrite), 64'd0);
    chk("rst_pwdata", 64'(m_pwdata), 64'd0);
    chk("rst_pstrb", 64'(m_pstrb), 64'd0);
    chk("rst_pprot", 64'(m_pprot), 64'd0);
    repeat (3) @(negedge bclk);
    bresetn = 1'b1;
    @(posedge bclk); #2;

    // Directed cases
    issue(32'h0000_2004, 1'b1, 3'd2, 4'h3, 32'hDEAD_BEEF, 0, 1'b0, 1'b0);
    issue(32'h0000_1003, 1'b0, 3'd0, 4'h1, 32'h0, 2, 1'b0, 1'b0);
    issue(32'h0000_5000, 1'b1, 3'd2, 4'h0, 32'hCAFE_F00D, 0, 1'b0, 1'b0);
    issue(32'h0000_0010, 1'b1, 3'd2, 4'h2, 32'h5555_AAAA, 1, 1'b1, 1'b0);
    issue(32'h0000_0010, 1'b0, 3'd2, 4'h2, 32'h0, 0, 1'b0, 1'b0);
    issue(32'h0000_2000, 1'b0, 3'd2, 4'h0, 32'h0, 0, 1'b0, 1'b1);
    issue(32'h0000_2008, 1'b1, 3'd1, 4'h1, 32'h1234_5678, 0, 1'b0, 1'b0);
    issue(32'h0000_2008, 1'b0, 3'd2, 4'h1, 32'h0, 0, 1'b0, 1'b0);
    issue(32'h0000_3004, 1'b0, 3'd2, 4'h0, 32'h0, TIMEOUT_CYC - 1, 1'b0, 1'b0);
    issue(32'h0000_4001, 1'b1, 3'd3, 4'h0, 32'h0, 0, 1'b0, 1'b0);
    issue(32'h0000_4001, 1'b1, 3'd0, 4'h8, 32'hA1B2_C3D4, 0, 1'b0, 1'b0);
    issue(32'h0000_4000, 1'b0, 3'd2, 4'h8, 32'h0, 0, 1'b0, 1'b0);
    drain();

    // Reset pulsed in the middle of an ACCESS phase
    ahb_mon_en = 1'b0;
    apb_mon_en = 1'b0;
    s_hsel   = 1'b1;
    s_htrans = 2'b10;
    s_haddr  = 32'h0000_3008;
    s_hwrite = 1'b0;
    s_hsize  = 3'd2;
    @(posedge bclk); #2;
    s_hsel   = 1'b0;
    s_htrans = 2'b00;
    guard = 0;
    while (!m_penable && guard < 20) begin
      @(posedge bclk); #2;
      guard++;
    end
    chk("rst_reach_access", 64'(m_penable), 64'd1);
    @(posedge bclk); #3;
    bresetn = 1'b0;
    #1;
    chk("arst_psel", 64'(m_psel), 64'd0);
    chk("arst_penable", 64'(m_penable), 64'd0);
    chk("arst_hreadyout", 64'(s_hreadyout), 64'd1);
    chk("arst_hresp", 64'(s_hresp), 64'd0);
    chk("arst_paddr", 64'(m_paddr), 64'd0);
    chk("arst_hrdata", 64'(s_hrdata), 64'd0);
    @(negedge bclk);
    bresetn = 1'b1;
    last_rdata = 32'h0;
    idle(2);
    ahb_mon_en = 1'b1;
    apb_mon_en = 1'b1;
    issue(32'h0000_3008, 1'b0, 3'd2, 4'h0, 32'h0, 0, 1'b0, 1'b0);

    // Randomised traffic, including out-of-map slots, bad sizes, slave errors and timeouts
    for (int n = 0; n < 70; n++) begin
      slot = $urandom_range(0, 5);
      size = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      off  = $urandom_range(0, 63);
      if (size <= 3'd2) off = off & ~((1 << size) - 1);
      issue(32'(slot << SLOT_W) + 32'(off), 1'($urandom_range(0, 1)), size,
            4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 7),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 11) == 0));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
